uart_rom_loader: RTL
====================

Name: uart_rom_loader

Overview:
- Boot-load controller that sequences the UART receive FIFO.
- It drains received bytes, parses a framed program image, writes 16-bit Hack instructions into instruction ROM at incrementing addresses, and verifies an XOR checksum.
- Holds the Hack CPU in reset while loading; releases it only on a clean load.
- Sits between the UART RX block (empty flag, read strobe, data byte) and the ROM write port.

Parameters:
ADDR_BITS, 15, ROM address width; maximum image is 2^ADDR_BITS words
TIMEOUT_CYCLES, 50000000, idle clocks allowed between bytes once a load has started (1 s at 50 MHz)
AUTO_START, 1, 1 = begin loading right after reset; 0 = wait for i_Start

Ports:
i_CLK  in  1  system clock
i_RESET  in  1  asynchronous, active-high reset
i_Start  in  1  one-cycle pulse; starts a (re)load from IDLE, DONE or ERROR; ignored while busy
i_UART_Empty  in  1  UART FIFO empty flag (1 = empty)
i_UART_Data  in  8  UART FIFO read data; valid one clock after the o_Read_EN cycle
o_Read_EN  out  1  one-cycle FIFO read strobe
o_ROM_Addr  out  ADDR_BITS  ROM write address
o_ROM_Data  out  16  ROM write data
o_ROM_WE  out  1  ROM write enable, one cycle per word
o_CPU_Reset  out  1  CPU reset hold; active high
o_Busy  out  1  load in progress
o_Done  out  1  level; last load completed with a good checksum
o_Error  out  1  level; last load failed
o_Error_Code  out  2  0 none, 1 timeout, 2 size overflow, 3 checksum mismatch

Behaviour:
- Reset values:
  - o_CPU_Reset=1; all other outputs 0.
  - State = LOAD_HDR_HI if AUTO_START=1, else IDLE.
- Frame format:
  - N_hi, N_lo (16-bit word count, big-endian).
  - N words, each hi byte then lo byte.
  - One checksum byte = XOR of every byte after the header.
- Byte fetch handshake:
  - When i_UART_Empty=0 and a byte is needed, pulse o_Read_EN for exactly one cycle.
  - Capture i_UART_Data on the following clock.
  - No further strobe until capture is done, so at most one outstanding read.
  - Minimum 2 clocks per byte.
- States and transitions:
  - IDLE: o_CPU_Reset=1. i_Start → LOAD_HDR_HI.
  - LOAD_HDR_HI / LOAD_HDR_LO: fetch the count bytes.
    - N > 2^ADDR_BITS → ERROR, code 2, without consuming further bytes.
    - N = 0 → LOAD_CSUM.
    - Otherwise → LOAD_HI.
  - LOAD_HI, then LOAD_LO, then WRITE.
    - In WRITE, o_ROM_WE=1 for one cycle with the assembled word at the current address.
    - Then increment the address.
    - If words written == N → LOAD_CSUM, else → LOAD_HI.
  - LOAD_CSUM: fetch one byte and compare it with the running XOR.
    - Match → DONE.
    - Mismatch → ERROR, code 3.
  - DONE: o_Done=1, o_CPU_Reset=0, o_Busy=0.
  - ERROR: o_Error=1, o_CPU_Reset=1, o_Busy=0.
- o_Busy is 1 in every LOAD_*/WRITE state.
- Starting a load:
  - Clears address, word counter, XOR accumulator, o_Done, o_Error and o_Error_Code.
  - Asserts o_CPU_Reset in the same cycle.
- Timeout:
  - The idle counter resets on every captured byte and on load start.
  - It counts only while a byte is awaited and i_UART_Empty=1.
  - In LOAD_HDR_HI the counter does not run, so the loader may wait forever for the first byte.
  - Counter reaching TIMEOUT_CYCLES → ERROR, code 1.
- Address: an image of exactly 2^ADDR_BITS words ends at the last address. No wrap write occurs because the count check precedes the write.
- Bytes arriving after DONE/ERROR are left in the FIFO; no read strobes are issued outside LOAD_* states.
- i_Start while busy is ignored. i_Start in DONE/ERROR restarts immediately.
- i_RESET mid-load:
  - Asynchronously returns to the reset state; no further o_ROM_WE.
  - ROM contents already written are undefined for use.

Decomposition:
- Package uart_loader_pkg holds:
  - State encoding constants.
  - Error code constants (ERR_NONE, ERR_TIMEOUT, ERR_SIZE, ERR_CSUM).
  - Frame header length constant (2).
- Sub-module uart_byte_fetch owns the read-strobe/capture handshake and the timeout counter.
  - Interface: req, timeout_en in; byte_valid, byte, timeout out.
- The top-level FSM does parsing, word assembly, addressing and the checksum.

Test Plan:
- AUTO_START=1. Send 00 02, 12 34, AB CD, csum 0x12^0x34^0xAB^0xCD=0x40.
  - → ROM writes addr0=0x1234, addr1=0xABCD.
  - o_Done=1, o_CPU_Reset=0, o_Error=0, exactly 5 read strobes after the header.
- Same image with csum 0x41 → o_Error=1, code 3, o_CPU_Reset stays 1; both ROM writes still occur.
- ADDR_BITS=4. Send header 00 11 (17 words) → ERROR code 2 immediately, zero ROM writes, no further o_Read_EN.
- TIMEOUT_CYCLES=100. Send 00 01, 55 then stall → ERROR code 1 at 100 idle clocks after byte 0x55; o_ROM_WE never asserted.
- Send 00 00, csum 00 → DONE with no ROM writes.
  - Then pulse i_Start and send a valid 1-word image 7F FF, csum 0x80 → o_Done drops during load, addr0=0x7FFF, DONE again.
- Assert i_RESET during the second word of a 3-word load.
  - → o_ROM_WE=0 and o_CPU_Reset=1 immediately.
  - After release, a full valid image loads from addr 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants for the UART boot ROM loader
// Purpose: FSM state encoding, error codes, frame header length and state
//          classification helpers used by the loader and its byte fetcher.
// Ports:   none (package)
package uart_loader_pkg;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_LOAD_HDR_HI = 4'd1;
  localparam logic [3:0] ST_LOAD_HDR_LO = 4'd2;
  localparam logic [3:0] ST_LOAD_HI     = 4'd3;
  localparam logic [3:0] ST_LOAD_LO     = 4'd4;
  localparam logic [3:0] ST_WRITE       = 4'd5;
  localparam logic [3:0] ST_LOAD_CSUM   = 4'd6;
  localparam logic [3:0] ST_DONE        = 4'd7;
  localparam logic [3:0] ST_ERROR       = 4'd8;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  // Word count prefix (N_hi, N_lo) preceding the payload.
  localparam int HDR_BYTES = 2;

  // States in which the loader is waiting for a byte from the FIFO.
  function automatic logic is_fetch_state(input logic [3:0] s);
    return (s == ST_LOAD_HDR_HI) || (s == ST_LOAD_HDR_LO) ||
           (s == ST_LOAD_HI)     || (s == ST_LOAD_LO)     ||
           (s == ST_LOAD_CSUM);
  endfunction

  function automatic logic is_busy_state(input logic [3:0] s);
    return is_fetch_state(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// rtl/uart_rom_loader_if.sv - UART FIFO / ROM write / CPU control bundle
// Purpose: groups every loader signal except clock and reset.
// Ports:   master = loader side (drives o_*), slave = environment side
//          (drives i_*: start pulse, FIFO empty flag and read data).
interface uart_rom_loader_if #(
  parameter int ADDR_BITS = 15
);
  logic                 i_Start;
  logic                 i_UART_Empty;
  logic [7:0]           i_UART_Data;
  logic                 o_Read_EN;
  logic [ADDR_BITS-1:0] o_ROM_Addr;
  logic [15:0]          o_ROM_Data;
  logic                 o_ROM_WE;
  logic                 o_CPU_Reset;
  logic                 o_Busy;
  logic                 o_Done;
  logic                 o_Error;
  logic [1:0]           o_Error_Code;

  modport master (
    input  i_Start, i_UART_Empty, i_UART_Data,
    output o_Read_EN, o_ROM_Addr, o_ROM_Data, o_ROM_WE,
           o_CPU_Reset, o_Busy, o_Done, o_Error, o_Error_Code
  );

  modport slave (
    output i_Start, i_UART_Empty, i_UART_Data,
    input  o_Read_EN, o_ROM_Addr, o_ROM_Data, o_ROM_WE,
           o_CPU_Reset, o_Busy, o_Done, o_Error, o_Error_Code
  );
endinterface

// File: rtl/uart_byte_fetch.sv
// rtl/uart_byte_fetch.sv - one-outstanding-read FIFO fetcher with idle timeout
// Purpose: strobes the UART FIFO when a byte is requested, captures the data
//          a clock later and flags a timeout when the FIFO stays empty.
// Ports:   clk, rst (async, active high); req / timeout_en from the FSM;
//          uart_empty, uart_data from the FIFO; read_en to the FIFO;
//          byte_valid (one-cycle) + byte_data, timeout (level) to the FSM.
module uart_byte_fetch #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       timeout_en,
  input  logic       uart_empty,
  input  logic [7:0] uart_data,
  output logic       read_en,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       timeout
);
  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic          pending;
  logic [CW-1:0] idle_cnt;

  assign timeout = (idle_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_en    <= 1'b0;
      pending    <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      idle_cnt   <= '0;
    end else begin
      // A new strobe waits until the previous byte has been consumed, so the
      // FSM can leave the fetch states without a read left in flight.
      read_en    <= req && !uart_empty && !read_en && !pending &&
                    !byte_valid && !timeout;
      pending    <= read_en;
      byte_valid <= pending;
      if (pending) byte_data <= uart_data;

      if (!timeout_en || byte_valid)
        idle_cnt <= '0;
      else if (uart_empty && !read_en && !pending && !timeout)
        idle_cnt <= idle_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_rom_loader.sv
// rtl/uart_rom_loader.sv - boot loader: UART frame -> Hack instruction ROM
// Purpose: parses N_hi N_lo, N big-endian words, XOR checksum; writes words to
//          ROM from address 0, holds the CPU in reset unless the load was clean.
// Ports:   i_CLK, i_RESET (async, active high); bus (master): start pulse,
//          UART FIFO read side, ROM write port, CPU reset, status/error code.
module uart_rom_loader #(
  parameter int ADDR_BITS      = 15,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter bit AUTO_START     = 1'b1
) (
  input logic               i_CLK,
  input logic               i_RESET,
  uart_rom_loader_if.master bus
);
  import uart_loader_pkg::*;

  localparam logic [3:0]  RESET_STATE = AUTO_START ? ST_LOAD_HDR_HI : ST_IDLE;
  localparam logic [16:0] MAX_WORDS   = 17'(1) << ADDR_BITS;

  logic [3:0]           state, state_d;
  logic [1:0]           err_d;
  logic [7:0]           hdr_hi, word_hi, csum;
  logic [15:0]          word_count, hdr_count;
  logic [16:0]          words_done;
  logic [ADDR_BITS-1:0] addr;
  logic [15:0]          rom_data;
  logic                 rom_we, busy, done, error;
  logic [1:0]           err_code;
  logic                 req, timeout_en, byte_valid, timeout, start_load;
  logic [7:0]           byte_data;

  assign req        = is_fetch_state(state);
  // The first header byte may take arbitrarily long to arrive.
  assign timeout_en = req && (state != ST_LOAD_HDR_HI);
  assign hdr_count  = {hdr_hi, byte_data};
  assign start_load = bus.i_Start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  uart_byte_fetch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fetch (
    .clk        (i_CLK),
    .rst        (i_RESET),
    .req        (req),
    .timeout_en (timeout_en),
    .uart_empty (bus.i_UART_Empty),
    .uart_data  (bus.i_UART_Data),
    .read_en    (bus.o_Read_EN),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .timeout    (timeout)
  );

  always_comb begin
    state_d = state;
    err_d   = ERR_NONE;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (start_load) state_d = ST_LOAD_HDR_HI;
      ST_LOAD_HDR_HI:
        if (byte_valid) state_d = ST_LOAD_HDR_LO;
      ST_LOAD_HDR_LO: begin
        if (timeout) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (byte_valid) begin
          // Size is rejected before any payload byte is read.
          if ({1'b0, hdr_count} > MAX_WORDS) begin
            state_d = ST_ERROR;
            err_d   = ERR_SIZE;
          end else if (hdr_count == 16'd0) begin
            state_d = ST_LOAD_CSUM;
          end else begin
            state_d = ST_LOAD_HI;
          end
        end
      end
      ST_LOAD_HI: begin
        if (timeout) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (byte_valid) begin
          state_d = ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: begin
        if (timeout) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (byte_valid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE:
        state_d = (words_done + 17'd1 == {1'b0, word_count}) ? ST_LOAD_CSUM : ST_LOAD_HI;
      ST_LOAD_CSUM: begin
        if (timeout) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (byte_valid) begin
          if (byte_data == csum) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state      <= RESET_STATE;
      hdr_hi     <= 8'h00;
      word_hi    <= 8'h00;
      csum       <= 8'h00;
      word_count <= 16'h0000;
      words_done <= 17'd0;
      addr       <= '0;
      rom_data   <= 16'h0000;
      rom_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state  <= state_d;
      busy   <= is_busy_state(state_d);
      rom_we <= 1'b0;

      if (start_load) begin
        addr       <= '0;
        words_done <= 17'd0;
        csum       <= 8'h00;
        done       <= 1'b0;
        error      <= 1'b0;
        err_code   <= ERR_NONE;
      end

      case (state)
        ST_LOAD_HDR_HI: if (byte_valid) hdr_hi <= byte_data;
        ST_LOAD_HDR_LO: if (byte_valid) word_count <= hdr_count;
        ST_LOAD_HI: if (byte_valid) begin
          word_hi <= byte_data;
          csum    <= csum ^ byte_data;
        end
        ST_LOAD_LO: if (byte_valid) begin
          rom_data <= {word_hi, byte_data};
          rom_we   <= 1'b1;
          csum     <= csum ^ byte_data;
        end
        // The write strobe is high during this state; advance afterwards.
        ST_WRITE: begin
          addr       <= addr + ADDR_BITS'(1);
          words_done <= words_done + 17'd1;
        end
        default: ;
      endcase

      if (state_d == ST_DONE && state != ST_DONE) done <= 1'b1;
      if (state_d == ST_ERROR && state != ST_ERROR) begin
        error    <= 1'b1;
        err_code <= err_d;
      end
    end
  end

  assign bus.o_ROM_Addr   = addr;
  assign bus.o_ROM_Data   = rom_data;
  assign bus.o_ROM_WE     = rom_we;
  assign bus.o_CPU_Reset  = (state != ST_DONE);
  assign bus.o_Busy       = busy;
  assign bus.o_Done       = done;
  assign bus.o_Error      = error;
  assign bus.o_Error_Code = err_code;
endmodule
